// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
//
// Input handshake: a byte is taken on any rising clk edge where in_valid and
// in_ready are both 1. in_valid may be raised or dropped at any time, and
// in_data only matters on a taking edge. in_ready comes from registered state
// only (count < DEPTH), so it never depends on in_valid or on a pop that
// happens in the same cycle.
//
// The serializer pops the head byte while idle. It then sends one start bit,
// eight data bits LSB first and one stop bit, each CLKS_PER_BIT cycles long.
// The line is driven from a register that lags the state register by one
// cycle, so the IDLE pop cycle shows up as one idle-high cycle between frames.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     uart_tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      shift_reg;
    logic [7:0]      shift_next;
    logic [15:0]     bit_cnt;
    logic [15:0]     bit_cnt_next;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_next;
    logic            tx_next;
    logic            bit_done;
    logic            push;
    logic            pop;

    assign in_ready = (count < FULL_COUNT);
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0);
    assign busy     = (state != IDLE) || (count != '0);
    assign bit_done = (bit_cnt == BIT_LAST);

    // Byte storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Serializer next-state, bit timing and line value for the current state.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        tx_next      = 1'b1;
        case (state)
            IDLE: begin
                tx_next      = 1'b1;
                bit_cnt_next = '0;
                bit_idx_next = '0;
                if (pop) begin
                    shift_next = mem[rd_ptr];
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_done) begin
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end else begin
                    bit_cnt_next = bit_cnt + 16'd1;
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (bit_done) begin
                    bit_cnt_next = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + 16'd1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (bit_done) begin
                    bit_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    bit_cnt_next = bit_cnt + 16'd1;
                end
            end
            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
                bit_idx_next = '0;
            end
        endcase
    end

    // Serializer registers; reset aborts any frame and raises the line at once.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            uart_tx   <= 1'b1;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            bit_idx   <= bit_idx_next;
            uart_tx   <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at CLKS_PER_BIT=4, DEPTH=16: cycle-exact table for a
// single frame, plus sequences for fill/drain, ordering, reset and wrap. A
// line decoder feeds a scoreboard that holds bytes in push order.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 10 * CPB + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          uart_tx;
    logic          busy;
    logic [CW-1:0] count;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    int            rx_cnt = 0;
    logic [7:0]    exp_q[$];
    int            start_q[$];

    logic          mon_active = 1'b0;
    int            mon_idx = 0;
    logic [7:0]    mon_shift = 8'h00;

    typedef struct {
        int            edge_n;
        logic          tx;
        logic          bsy;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs[13];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .count    (count)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard input side: every accepted byte is expected on the line.
    always @(posedge clk) begin
        if (!resetn) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            acc_cnt <= acc_cnt + 1;
        end
    end

    // Line decoder: samples mid-bit on negedges, compares finished bytes.
    always @(negedge clk) begin
        if (!resetn) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (uart_tx == 1'b0) begin
                mon_active <= 1'b1;
                mon_idx    <= 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_idx <= mon_idx + 1;
            if (mon_idx + 1 == CPB / 2) begin
                check("start_bit", uart_tx, 1'b0);
            end else if (mon_idx + 1 == 9 * CPB + CPB / 2) begin
                check("stop_bit", uart_tx, 1'b1);
                rx_cnt     <= rx_cnt + 1;
                mon_active <= 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %02h expected no frame", mon_shift);
                end else begin
                    check("frame_data", mon_shift, exp_q.pop_front());
                end
            end else if ((mon_idx + 1) % CPB == CPB / 2) begin
                mon_shift <= {uart_tx, mon_shift[7:1]};
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || mon_active) && n < 4000) begin
            tick();
            n++;
        end
        check({"idle_", name}, 32'(n < 4000), 1);
        repeat (3) tick();
    endtask

    initial begin
        int vi;
        int a0;
        int r0;
        int s0;
        int idx;
        int n;
        logic rdy;
        logic [7:0] ord[4];

        // Single-frame table for 0x55 pushed at edge 0: bits 1,0,1,0,1,0,1,0.
        vecs[0]  = '{0,  1'b1, 1'b1, CW'(1)};
        vecs[1]  = '{1,  1'b1, 1'b1, CW'(0)};
        vecs[2]  = '{2,  1'b0, 1'b1, CW'(0)};
        vecs[3]  = '{5,  1'b0, 1'b1, CW'(0)};
        vecs[4]  = '{6,  1'b1, 1'b1, CW'(0)};
        vecs[5]  = '{9,  1'b1, 1'b1, CW'(0)};
        vecs[6]  = '{10, 1'b0, 1'b1, CW'(0)};
        vecs[7]  = '{14, 1'b1, 1'b1, CW'(0)};
        vecs[8]  = '{18, 1'b0, 1'b1, CW'(0)};
        vecs[9]  = '{34, 1'b0, 1'b1, CW'(0)};
        vecs[10] = '{37, 1'b0, 1'b1, CW'(0)};
        vecs[11] = '{38, 1'b1, 1'b1, CW'(0)};
        vecs[12] = '{42, 1'b1, 1'b0, CW'(0)};

        // Reset, with a push attempted while reset is low.
        resetn   = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) tick();
        check("rst_tx", uart_tx, 1'b1);
        check("rst_count", count, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        resetn   = 1'b1;
        tick();
        check("rst_push_ignored", count, 0);
        check("rst_push_ignored_busy", busy, 1'b0);
        repeat (3) tick();

        // Single byte, cycle-exact against the table.
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        vi = 0;
        for (int e = 0; e <= 42; e++) begin
            while (vi < 13 && vecs[vi].edge_n == e) begin
                check($sformatf("single_tx_e%0d", e), uart_tx, vecs[vi].tx);
                check($sformatf("single_busy_e%0d", e), busy, vecs[vi].bsy);
                check($sformatf("single_count_e%0d", e), count, vecs[vi].cnt);
                vi++;
            end
            if (e < 42) tick();
        end
        wait_idle("single");

        // Ordering and frame spacing.
        ord[0] = 8'h48; ord[1] = 8'h69; ord[2] = 8'h0D; ord[3] = 8'h0A;
        r0 = rx_cnt;
        s0 = start_q.size();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = ord[i];
            tick();
        end
        in_valid = 1'b0;
        wait_idle("order");
        check("order_frames", rx_cnt - r0, 4);
        if (start_q.size() >= s0 + 4) begin
            for (int i = 1; i < 4; i++) begin
                check($sformatf("order_spacing_%0d", i), start_q[s0 + i] - start_q[s0 + i - 1], FRAME);
            end
        end

        // Fill with in_valid held, then drain past full and push on a pop edge.
        a0 = acc_cnt;
        in_data  = 8'h80;
        in_valid = 1'b1;
        for (int e = 0; e <= 42; e++) begin
            rdy = in_ready;
            tick();
            if (rdy) in_data = in_data + 8'd1;
            if (e == 17) begin
                check("fill_accepted", acc_cnt - a0, 17);
                check("fill_count", count, DEPTH);
                check("fill_ready", in_ready, 1'b0);
            end
        end
        check("drain_count", count, DEPTH - 1);
        check("drain_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        for (int e = 43; e < 42 + FRAME; e++) tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("push_pop_count", count, DEPTH - 1);
        check("fill_total", acc_cnt - a0, 18);
        wait_idle("fill");

        // Reset during the data bits of 0xA5 with three bytes queued.
        r0 = rx_cnt;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        resetn = 1'b0;
        tick();
        check("midrst_tx", uart_tx, 1'b1);
        check("midrst_count", count, 0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", in_ready, 1'b1);
        resetn = 1'b1;
        repeat (200) tick();
        check("midrst_no_frames", rx_cnt - r0, 0);
        check("midrst_idle_busy", busy, 1'b0);
        check("midrst_line_high", uart_tx, 1'b1);

        // 40 bytes at a random duty, wrapping the pointers more than twice.
        r0  = rx_cnt;
        idx = 0;
        n   = 0;
        while (idx < 40 && n < 20000) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'(idx);
            rdy      = in_ready;
            tick();
            if (in_valid && rdy) idx++;
            n++;
        end
        in_valid = 1'b0;
        check("wrap_pushed", idx, 40);
        wait_idle("wrap");
        check("wrap_frames", rx_cnt - r0, 40);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
